// File: rtl/multicycle_control_fsm.sv
// Multicycle main control unit for a MIPS-subset CPU.
//
// Steps each instruction through FETCH, DECODE and an execute/memory phase,
// and drives every datapath select and enable line. Each instruction retires
// with exactly one PCWrite pulse, and instr_count counts those pulses.
//
// Handshake: mem_ready is a level from memory meaning "the current access
// has completed this cycle". The FSM samples it only in FETCH, LW_WB and
// SW_MEM. Writes that depend on memory (register write for LW, memWrite for
// SW) and the retiring PCWrite are asserted only in the cycle mem_ready=1,
// so each is a single-cycle pulse. mem_ready is ignored in every other state.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   instr[31:0]       current instruction (held stable by the datapath)
//   mem_ready         memory access complete
//   PCWrite .. jumpReg  datapath controls (ALUSrcB/PCSrc 2 bits, ALUControl 5)
//   state[3:0]        current FSM state (debug)
//   halted            an illegal instruction was seen; leaves only on reset
//   instr_count[15:0] retired-instruction counter, wraps at 0xFFFF
module multicycle_control_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        secondRound,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic [4:0]  ALUControl,
  output logic        memToReg,
  output logic        memWrite,
  output logic        regWriteEnable,
  output logic        regDst,
  output logic        branchEnable,
  output logic        jump,
  output logic        jumpReg,
  output logic [3:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_NORI  = 6'b001111;
  localparam logic [5:0] OP_BLT   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_NOR = 5'd4;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_LW_ADDR = 4'd4,
    S_LW_WB   = 4'd5,
    S_SW_MEM  = 4'd6,
    S_BR_EVAL = 4'd7,
    S_JUMP    = 4'd8,
    S_HALT    = 4'd15
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] count_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // R-type ALU decode; funct_ok is low for any funct without an operation.
  logic [4:0] alu_r;
  logic       funct_ok;
  always_comb begin
    alu_r    = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_r = ALU_ADD;
      FN_SUB:  alu_r = ALU_SUB;
      FN_AND:  alu_r = ALU_AND;
      FN_OR:   alu_r = ALU_OR;
      FN_NOR:  alu_r = ALU_NOR;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (PCWrite) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    PCWrite        = 1'b0;
    IorD           = 1'b0;
    IRWrite        = 1'b0;
    ALUSrcA        = 1'b0;
    secondRound    = 1'b0;
    ALUSrcB        = 2'b00;
    PCSrc          = 2'b00;
    ALUControl     = ALU_ADD;
    memToReg       = 1'b0;
    memWrite       = 1'b0;
    regWriteEnable = 1'b0;
    regDst         = 1'b0;
    branchEnable   = 1'b0;
    jump           = 1'b0;
    jumpReg        = 1'b0;
    halted         = 1'b0;

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes PC + (SignImm<<2) so the branch target is captured
        // here, before the instruction class is known.
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b11;
        ALUControl   = ALU_ADD;
        branchEnable = 1'b1;
        case (opcode)
          OP_RTYPE:        state_d = (funct == FN_JR) ? S_JUMP : S_EXEC_R;
          OP_ADDI, OP_NORI: state_d = S_EXEC_I;
          OP_LW:           state_d = S_LW_ADDR;
          OP_SW:           state_d = S_SW_MEM;
          OP_BLT:          state_d = S_BR_EVAL;
          OP_J, OP_JAL:    state_d = S_JUMP;
          default:         state_d = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        if (funct_ok) begin
          ALUSrcB        = 2'b00;
          ALUControl     = alu_r;
          regDst         = 1'b1;
          regWriteEnable = 1'b1;
          PCSrc          = 2'b00;
          PCWrite        = 1'b1;
          state_d        = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_EXEC_I: begin
        ALUSrcB        = 2'b10;
        ALUControl     = (opcode == OP_NORI) ? ALU_NOR : ALU_ADD;
        regWriteEnable = 1'b1;
        PCWrite        = 1'b1;
        state_d        = S_FETCH;
      end
      S_LW_ADDR: begin
        ALUSrcB     = 2'b10;
        ALUControl  = ALU_ADD;
        IorD        = 1'b1;
        secondRound = 1'b1;
        state_d     = S_LW_WB;
      end
      S_LW_WB: begin
        // Address drives stay up so the memory sees a stable address
        // for the whole stall.
        ALUSrcB     = 2'b10;
        ALUControl  = ALU_ADD;
        IorD        = 1'b1;
        secondRound = 1'b1;
        memToReg    = 1'b1;
        if (mem_ready) begin
          regWriteEnable = 1'b1;
          PCWrite        = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_SW_MEM: begin
        ALUSrcB     = 2'b10;
        ALUControl  = ALU_ADD;
        IorD        = 1'b1;
        secondRound = 1'b1;
        if (mem_ready) begin
          memWrite = 1'b1;
          PCWrite  = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BR_EVAL: begin
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OP_J:   PCSrc = 2'b01;
          OP_JAL: begin
            PCSrc          = 2'b01;
            jump           = 1'b1;
            memToReg       = 1'b1;
            regWriteEnable = 1'b1;
          end
          default: begin
            // Only JR reaches JUMP with a non-jump opcode.
            PCSrc   = 2'b11;
            jumpReg = 1'b1;
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    // Reset cycle: silence everything so an aborted instruction never
    // writes a register or memory, even with mem_ready high.
    if (reset) begin
      state_d        = S_FETCH;
      PCWrite        = 1'b0;
      IorD           = 1'b0;
      IRWrite        = 1'b0;
      ALUSrcA        = 1'b0;
      secondRound    = 1'b0;
      ALUSrcB        = 2'b00;
      PCSrc          = 2'b00;
      ALUControl     = ALU_ADD;
      memToReg       = 1'b0;
      memWrite       = 1'b0;
      regWriteEnable = 1'b0;
      regDst         = 1'b0;
      branchEnable   = 1'b0;
      jump           = 1'b0;
      jumpReg        = 1'b0;
      halted         = 1'b0;
    end
  end

  assign state       = reset ? 4'd0  : state_q;
  assign instr_count = reset ? 16'd0 : count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. A behavioural model expands
// each instruction (by its class and chosen memory wait counts) into the
// per-cycle list of expected state, controls and mem_ready, which a
// scoreboard queue checks cycle by cycle against the DUT.
module tb_multicycle_control_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IorD, IRWrite, ALUSrcA, secondRound;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [4:0]  ALUControl;
  logic        memToReg, memWrite, regWriteEnable, regDst, branchEnable, jump, jumpReg;
  logic [3:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  multicycle_control_fsm dut (
    .clock(clock), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .secondRound(secondRound), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .memToReg(memToReg), .memWrite(memWrite),
    .regWriteEnable(regWriteEnable), .regDst(regDst), .branchEnable(branchEnable),
    .jump(jump), .jumpReg(jumpReg), .state(state), .halted(halted),
    .instr_count(instr_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- control word ----------------
  typedef struct packed {
    logic       pc_write, iord, ir_write, alu_src_a, second_round;
    logic [1:0] alu_src_b, pc_src;
    logic [4:0] alu_ctl;
    logic       mem_to_reg, mem_write, reg_we, reg_dst, br_en, jump, jump_reg, halted;
  } ctl_t;

  ctl_t act;
  assign act = {PCWrite, IorD, IRWrite, ALUSrcA, secondRound, ALUSrcB, PCSrc,
                ALUControl, memToReg, memWrite, regWriteEnable, regDst,
                branchEnable, jump, jumpReg, halted};

  // ---------------- scoreboard ----------------
  // entry = {mem_ready to drive, expected state[3:0], expected ctl_t}
  logic [26:0] exp_q[$];
  logic [15:0] model_count = 16'd0;
  int total = 0;
  int bad = 0;

  task automatic push(input logic mr, input logic [3:0] st, input ctl_t c);
    exp_q.push_back({mr, st, c});
  endtask

  // Expand one instruction into expected cycles. fw = FETCH wait cycles,
  // mw = memory wait cycles in LW_WB / SW_MEM.
  task automatic model_instr(input logic [31:0] ins, input int fw, input int mw);
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t c;
    op = ins[31:26];
    fn = ins[5:0];
    c = '0; c.ir_write = 1'b1;
    repeat (fw) push(1'b0, 4'd0, c);
    push(1'b1, 4'd0, c);
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.br_en = 1'b1;
    push(1'($urandom_range(0, 1)), 4'd1, c);
    c = '0;
    if (op == 6'b000000 && fn == 6'h08) begin
      c.pc_write = 1'b1; c.pc_src = 2'b11; c.jump_reg = 1'b1;
      push(1'($urandom_range(0, 1)), 4'd8, c);
    end else if (op == 6'b000000) begin
      case (fn)
        6'h20: c.alu_ctl = 5'd0;
        6'h22: c.alu_ctl = 5'd1;
        6'h24: c.alu_ctl = 5'd2;
        6'h25: c.alu_ctl = 5'd3;
        6'h27: c.alu_ctl = 5'd4;
        default: c.halted = 1'b1;  // marker: illegal funct
      endcase
      if (c.halted) begin
        push(1'($urandom_range(0, 1)), 4'd2, '0);
        c = '0; c.halted = 1'b1;
        repeat (10) push(1'($urandom_range(0, 1)), 4'd15, c);
      end else begin
        c.reg_dst = 1'b1; c.reg_we = 1'b1; c.pc_write = 1'b1;
        push(1'($urandom_range(0, 1)), 4'd2, c);
      end
    end else if (op == 6'b001000 || op == 6'b001111) begin
      c.alu_src_b = 2'b10; c.alu_ctl = (op == 6'b001111) ? 5'd4 : 5'd0;
      c.reg_we = 1'b1; c.pc_write = 1'b1;
      push(1'($urandom_range(0, 1)), 4'd3, c);
    end else if (op == 6'b100011) begin
      c.alu_src_b = 2'b10; c.iord = 1'b1; c.second_round = 1'b1;
      push(1'($urandom_range(0, 1)), 4'd4, c);
      c.mem_to_reg = 1'b1;
      repeat (mw) push(1'b0, 4'd5, c);
      c.reg_we = 1'b1; c.pc_write = 1'b1;
      push(1'b1, 4'd5, c);
    end else if (op == 6'b101011) begin
      c.alu_src_b = 2'b10; c.iord = 1'b1; c.second_round = 1'b1;
      repeat (mw) push(1'b0, 4'd6, c);
      c.mem_write = 1'b1; c.pc_write = 1'b1;
      push(1'b1, 4'd6, c);
    end else if (op == 6'b000100) begin
      c.alu_ctl = 5'd1; c.pc_src = 2'b10; c.pc_write = 1'b1;
      push(1'($urandom_range(0, 1)), 4'd7, c);
    end else if (op == 6'b000010) begin
      c.pc_src = 2'b01; c.pc_write = 1'b1;
      push(1'($urandom_range(0, 1)), 4'd8, c);
    end else if (op == 6'b000011) begin
      c.pc_src = 2'b01; c.pc_write = 1'b1; c.jump = 1'b1;
      c.mem_to_reg = 1'b1; c.reg_we = 1'b1;
      push(1'($urandom_range(0, 1)), 4'd8, c);
    end else begin
      c.halted = 1'b1;
      repeat (10) push(1'($urandom_range(0, 1)), 4'd15, c);
    end
  endtask

  // Drive and check every queued cycle; inputs change at negedge, outputs
  // are sampled 1 time unit later, well away from the rising edge.
  task automatic drain(input logic [31:0] ins, input string tag);
    logic [26:0] e;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clock);
      reset = 1'b0;
      instr = ins;
      mem_ready = e[26];
      #1;
      total++;
      if ({state, act, instr_count} !== {e[25:0], model_count}) begin
        bad++;
        $display("FAIL %s cyc%0d: got state=%0d ctl=%h cnt=%0d, want state=%0d ctl=%h cnt=%0d",
                 tag, cyc, state, act, instr_count, e[25:22], e[21:0], model_count);
      end
      if (e[21]) model_count = model_count + 16'd1;
      cyc++;
    end
  endtask

  task automatic do_reset(input logic mr, input string tag);
    @(negedge clock);
    reset = 1'b1;
    mem_ready = mr;
    #1;
    total++;
    if ({state, act, instr_count} !== '0) begin
      bad++;
      $display("FAIL %s: outputs during reset got state=%0d ctl=%h cnt=%0d, want all 0",
               tag, state, act, instr_count);
    end
    model_count = 16'd0;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'($urandom), 5'($urandom), 16'($urandom)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(1'b1, "reset_a");
    do_reset(1'b0, "reset_b");
  endtask

  task automatic test_add();
    model_instr(32'h00221820, 0, 0);
    drain(32'h00221820, "add");
    @(posedge clock); #1;
    total++;
    if (state !== 4'd0 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL add_retire: got state=%0d cnt=%0d, want state=0 cnt=1", state, instr_count);
    end
  endtask

  task automatic test_random_mix();
    logic [31:0] ins;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 12))
        0: ins = rtype(6'h20);
        1: ins = rtype(6'h22);
        2: ins = rtype(6'h24);
        3: ins = rtype(6'h25);
        4: ins = rtype(6'h27);
        5: ins = {6'd0, 5'($urandom), 15'd0, 6'h08};
        6: ins = itype(6'b001000);
        7: ins = itype(6'b001111);
        8: ins = itype(6'b100011);
        9: ins = itype(6'b101011);
        10: ins = itype(6'b000100);
        11: ins = {6'b000010, 26'($urandom)};
        default: ins = {6'b000011, 26'($urandom)};
      endcase
      model_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
      drain(ins, "random");
    end
  endtask

  task automatic test_lw_stall();
    model_instr(32'h8C220004, 1, 3);
    drain(32'h8C220004, "lw_stall");
  endtask

  task automatic test_sw_stall();
    model_instr(32'hAC220008, 0, 2);
    drain(32'hAC220008, "sw_stall");
  endtask

  task automatic test_jal_jr();
    model_instr(32'h0C000010, 0, 0);
    drain(32'h0C000010, "jal");
    model_instr(32'h03E00008, 0, 0);
    drain(32'h03E00008, "jr");
  endtask

  task automatic test_halt();
    model_instr(32'hFC000000, 0, 0);
    drain(32'hFC000000, "halt_op");
    do_reset(1'b1, "halt_reset");
    model_instr(32'h00221820, 0, 0);  // first cycle proves FETCH, halted=0, cnt=0
    drain(32'h00221820, "after_halt");
    model_instr(rtype(6'h3F), 0, 0);
    drain({6'd0, 20'h12345, 6'h3F}, "bad_funct");
    do_reset(1'b0, "bad_funct_reset");
  endtask

  task automatic test_reset_in_sw();
    ctl_t c;
    // FETCH and DECODE of a store, then reset lands in SW_MEM with mem_ready=1.
    c = '0; c.ir_write = 1'b1;
    push(1'b1, 4'd0, c);
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b11; c.br_en = 1'b1;
    push(1'b0, 4'd1, c);
    drain(32'hAC220008, "sw_pre_reset");
    do_reset(1'b1, "reset_in_sw");
    @(posedge clock); #1;
    total++;
    if (state !== 4'd0 || memWrite !== 1'b0 || instr_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_in_sw_next: got state=%0d memWrite=%0b cnt=%0d, want 0 0 0",
               state, memWrite, instr_count);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1, "wrap_reset");
    for (int i = 0; i < 65536; i++) begin
      repeat (3) begin
        @(negedge clock);
        reset = 1'b0;
        instr = 32'h00221820;
        mem_ready = 1'b1;
      end
      model_count = model_count + 16'd1;
      if (i == 65534) begin
        @(posedge clock); #1;
        total++;
        if (instr_count !== 16'hFFFF) begin
          bad++;
          $display("FAIL wrap_ffff: got cnt=%h want ffff", instr_count);
        end
      end
    end
    @(posedge clock); #1;
    total++;
    if (instr_count !== model_count || state !== 4'd0) begin
      bad++;
      $display("FAIL wrap_zero: got cnt=%h state=%0d want cnt=%h state=0",
               instr_count, state, model_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_random_mix();
    test_lw_stall();
    test_sw_stall();
    test_jal_jr();
    test_halt();
    test_reset_in_sw();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
